// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   - Default geometry of the instruction cache (line count, significant address bits).
//   - Fetch FSM state encoding.
//   - Small helper used when deciding whether a new lookup may be consumed.
package inst_fetch_pkg;

    // Direct-mapped, one 32-bit word per line.
    localparam int unsigned ICACHE_LINES_DEF = 16;
    // Byte-address bits actually decoded by the memory bus (17:0).
    localparam int unsigned ADDR_W_DEF       = 18;

    typedef enum logic [0:0] {
        StIdle, // lookup in progress every cycle the output slot is free
        StMiss  // memory read outstanding, request held stable
    } fetch_state_e;

    // The output register can take a new instruction when it is empty or
    // when its current contents are being accepted this cycle.
    function automatic logic slot_free(input logic valid, input logic ready);
        return !valid || ready;
    endfunction

endpackage

// File: rtl/inst_fetch_icache_ram.sv
// Instruction cache storage: data and tag arrays for a direct-mapped cache of
// one-word lines. Combinational read, single synchronous write port. Valid bits
// are kept by the owner so that they can be cleared by reset; these arrays are
// never reset.
//
// Ports:
//   clk      in   write clock
//   wr_en    in   write strobe (line fill)
//   wr_idx   in   line index to write
//   wr_tag   in   tag stored with the line
//   wr_data  in   instruction word stored in the line
//   rd_idx   in   line index to read
//   rd_tag   out  tag of the addressed line
//   rd_data  out  data of the addressed line
module inst_fetch_icache_ram #(
    parameter int unsigned LINES = 16,
    parameter int unsigned IDX_W = 4,
    parameter int unsigned TAG_W = 12
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data
);

    logic [31:0]      data_mem [LINES];
    logic [TAG_W-1:0] tag_mem  [LINES];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_idx] <= wr_data;
            tag_mem[wr_idx]  <= wr_tag;
        end
    end

    assign rd_data = data_mem[rd_idx];
    assign rd_tag  = tag_mem[rd_idx];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit with a small direct-mapped instruction cache.
// Looks up the current PC every cycle the output slot is free; a hit presents
// the instruction on the next edge (one instruction per cycle), a miss issues a
// single held read request to the memory controller and refills the line.
// A redirect (flush/jump) restarts fetch at a new PC and discards any
// in-flight fill. rdy low freezes all state.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-low reset
//   rdy           in   global ready; low freezes everything
//   redirect_flg  in   flush / jump request
//   redirect_pc   in   new fetch PC, valid with redirect_flg
//   mem_req       out  instruction read request to memory controller
//   mem_addr      out  address of the request
//   mem_done      in   one-cycle pulse, mem_data valid
//   mem_data      in   returned instruction word
//   out_valid     out  out_inst/out_pc hold a fetched instruction
//   out_ready     in   downstream accepts when out_valid is high
//   out_inst      out  fetched instruction
//   out_pc        out  PC of out_inst
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int unsigned ICACHE_LINES = ICACHE_LINES_DEF,
    parameter int unsigned ADDR_W       = ADDR_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        redirect_flg,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
);

    localparam int unsigned IDX_W = $clog2(ICACHE_LINES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

    fetch_state_e            state_q;
    logic [31:0]             pc_q;
    logic [ICACHE_LINES-1:0] valid_q;
    logic                    out_valid_q;
    logic [31:0]             out_inst_q;
    logic [31:0]             out_pc_q;
    logic                    mem_req_q;
    logic [31:0]             mem_addr_q;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_data;
    logic             hit;
    logic             free;
    logic             fill_en;

    // PCs are word aligned; the low bits of a redirect target are dropped.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign idx  = pc_q[IDX_W+1:2];
    assign tag  = pc_q[ADDR_W-1:IDX_W+2];
    assign hit  = valid_q[idx] && (rd_tag == tag);
    assign free = slot_free(out_valid_q, out_ready);

    // pc_q is held while a miss is outstanding, so it still indexes the line
    // being refilled. A coincident redirect wins and the fill is dropped.
    assign fill_en = rdy && !redirect_flg && (state_q == StMiss) && mem_done;

    inst_fetch_icache_ram #(
        .LINES (ICACHE_LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_icache_ram (
        .clk     (clk),
        .wr_en   (fill_en),
        .wr_idx  (idx),
        .wr_tag  (tag),
        .wr_data (mem_data),
        .rd_idx  (idx),
        .rd_tag  (rd_tag),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            pc_q        <= '0;
            valid_q     <= '0;
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            out_pc_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
        end else if (rdy) begin
            if (redirect_flg) begin
                // Overrides hit, miss, acceptance and fill completion alike.
                pc_q        <= {redirect_pc[31:2], 2'b00};
                out_valid_q <= 1'b0;
                mem_req_q   <= 1'b0;
                state_q     <= StIdle;
            end else begin
                case (state_q)
                    StIdle: begin
                        // An occupied, unaccepted slot blocks the lookup; pc holds.
                        if (free) begin
                            if (hit) begin
                                out_valid_q <= 1'b1;
                                out_inst_q  <= rd_data;
                                out_pc_q    <= pc_q;
                                pc_q        <= pc_q + 32'd4;
                            end else begin
                                out_valid_q <= 1'b0;
                                mem_req_q   <= 1'b1;
                                mem_addr_q  <= pc_q;
                                state_q     <= StMiss;
                            end
                        end
                    end
                    StMiss: begin
                        if (out_valid_q && out_ready) begin
                            out_valid_q <= 1'b0;
                        end
                        if (mem_done) begin
                            // Data/tag written by the RAM; the next lookup hits.
                            valid_q[idx] <= 1'b1;
                            mem_req_q    <= 1'b0;
                            state_q      <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign out_valid = out_valid_q;
    assign out_inst  = out_inst_q;
    assign out_pc    = out_pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    localparam int MemLat = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_out_t;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        redirect_flg;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    exp_out_t    exp_out [$];
    logic [31:0] exp_req [$];

    inst_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .redirect_flg (redirect_flg),
        .redirect_pc  (redirect_pc),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_done     (mem_done),
        .mem_data     (mem_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_inst     (out_inst),
        .out_pc       (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_req(input logic [31:0] a);
        exp_req.push_back(a);
    endtask

    task automatic push_out(input logic [31:0] pc);
        exp_out_t e;
        e.pc   = pc;
        e.inst = mem_word(pc);
        exp_out.push_back(e);
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_flg = 1'b1;
        redirect_pc  = pc;
        tick();
        redirect_flg = 1'b0;
    endtask

    task automatic wait_out_pc(input logic [31:0] pc, output int at_cyc);
        logic found = 1'b0;
        at_cyc = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (out_valid && out_pc == pc) begin
                found  = 1'b1;
                at_cyc = cyc;
            end
        end
        check_eq("wait_out", 32'(found), 32'd1);
    endtask

    task automatic wait_req(output int at_cyc);
        logic found = 1'b0;
        at_cyc = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (mem_req) begin
                found  = 1'b1;
                at_cyc = cyc;
            end
        end
        check_eq("wait_req", 32'(found), 32'd1);
    endtask

    task automatic wait_mem_done();
        logic found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (mem_done) found = 1'b1;
        end
        check_eq("wait_mem_done", 32'(found), 32'd1);
    endtask

    // Memory controller model: fixed latency from request to done pulse.
    initial begin
        logic        busy = 1'b0;
        int          cnt = 0;
        logic [31:0] lat_addr = '0;
        mem_done = 1'b0;
        mem_data = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_done = 1'b0;
            if (!rst) begin
                busy = 1'b0;
            end else if (rdy) begin
                if (busy) begin
                    cnt--;
                    if (cnt == 0) begin
                        mem_done = 1'b1;
                        mem_data = mem_word(lat_addr);
                        busy     = 1'b0;
                    end
                end else if (mem_req) begin
                    busy     = 1'b1;
                    cnt      = MemLat;
                    lat_addr = mem_addr;
                end
            end
        end
    end

    // Scoreboard: accepted outputs and new requests are popped and compared.
    initial begin
        logic        prev_req = 1'b0;
        logic [31:0] cur_req = '0;
        exp_out_t    e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (rdy && out_valid && out_ready) begin
                    check_eq("out_expected", 32'(exp_out.size() != 0), 32'd1);
                    if (exp_out.size() != 0) begin
                        e = exp_out.pop_front();
                        check_eq("out_pc", out_pc, e.pc);
                        check_eq("out_inst", out_inst, e.inst);
                    end
                end
                if (mem_req && !prev_req) begin
                    check_eq("req_expected", 32'(exp_req.size() != 0), 32'd1);
                    if (exp_req.size() != 0) begin
                        cur_req = exp_req.pop_front();
                        check_eq("req_addr", mem_addr, cur_req);
                    end
                end else if (mem_req) begin
                    check_eq("req_hold", mem_addr, cur_req);
                end
                prev_req = mem_req;
            end else begin
                prev_req = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_req;
        int t_out;
        rst          = 1'b0;
        rdy          = 1'b1;
        redirect_flg = 1'b0;
        redirect_pc  = '0;
        out_ready    = 1'b1;

        // Reset state.
        repeat (3) tick();
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_inst", out_inst, 32'h0);
        check_eq("rst_out_pc", out_pc, 32'h0);
        check_eq("rst_mem_req", 32'(mem_req), 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'h0);

        // Cold fetch of 0x0..0xC, first-miss latency.
        for (int i = 0; i < 4; i++) begin
            push_req(32'(i * 4));
            push_out(32'(i * 4));
        end
        rst = 1'b1;
        wait_req(t_req);
        wait_out_pc(32'h0, t_out);
        check_eq("miss_latency", 32'(t_out - t_req), 32'(MemLat + 2));
        check_eq("first_inst", out_inst, 32'h0000_0013);
        wait_out_pc(32'hC, t_out);

        // Stall with the slot occupied.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_valid", 32'(out_valid), 32'd1);
            check_eq("stall_pc", out_pc, 32'hC);
            check_eq("stall_inst", out_inst, mem_word(32'hC));
            check_eq("stall_req", 32'(mem_req), 32'd0);
        end

        // Accept 0xC while jumping back to 0: loop runs fully from cache.
        for (int i = 0; i < 4; i++) push_out(32'(i * 4));
        out_ready = 1'b1;
        redirect_to(32'h0);
        check_eq("redir_valid", 32'(out_valid), 32'd0);
        check_eq("redir_req", 32'(mem_req), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("loop_valid", 32'(out_valid), 32'd1);
            check_eq("loop_req", 32'(mem_req), 32'd0);
        end

        // Conflict: 0x40 evicts 0x0, then 0x0 misses again.
        push_req(32'h40);
        push_out(32'h40);
        redirect_to(32'h40);
        wait_out_pc(32'h40, t_out);
        push_req(32'h0);
        push_out(32'h0);
        redirect_to(32'h0);
        wait_out_pc(32'h0, t_out);

        // Redirect coinciding with the fill completion for 0x40.
        push_req(32'h40);
        redirect_to(32'h40);
        wait_mem_done();
        push_req(32'h100);
        push_out(32'h100);
        redirect_to(32'h100);
        check_eq("drop_valid", 32'(out_valid), 32'd0);
        check_eq("drop_req", 32'(mem_req), 32'd0);
        wait_out_pc(32'h100, t_out);

        // Dropped fill must not disturb another line: 0x4 still hits.
        push_req(32'h44);
        redirect_to(32'h44);
        wait_mem_done();
        push_out(32'h4);
        redirect_to(32'h4);
        wait_out_pc(32'h4, t_out);

        // Reset while a miss is outstanding.
        push_req(32'h200);
        redirect_to(32'h200);
        wait_req(t_req);
        repeat (2) tick();
        check_eq("pre_rst_req", 32'(mem_req), 32'd1);
        rst = 1'b0;
        #1;
        check_eq("arst_out_valid", 32'(out_valid), 32'd0);
        check_eq("arst_out_inst", out_inst, 32'h0);
        check_eq("arst_out_pc", out_pc, 32'h0);
        check_eq("arst_mem_req", 32'(mem_req), 32'd0);
        check_eq("arst_mem_addr", mem_addr, 32'h0);
        repeat (2) tick();
        push_req(32'h0);
        push_out(32'h0);
        rst = 1'b1;
        wait_out_pc(32'h0, t_out);

        // rdy low freezes everything after the word at 0x0 is taken.
        @(negedge clk);
        #1;
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("frz_valid", 32'(out_valid), 32'd1);
            check_eq("frz_pc", out_pc, 32'h0);
            check_eq("frz_inst", out_inst, 32'h0000_0013);
            check_eq("frz_req", 32'(mem_req), 32'd0);
            check_eq("frz_addr", mem_addr, 32'h0);
        end

        check_eq("out_drained", 32'(exp_out.size()), 32'd0);
        check_eq("req_drained", 32'(exp_req.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
